bin2stoch_gen: RTL and testbench

- Binary-to-stochastic bitstream generator, the transmit side of the stochastic datapath.
- Accepts a WIDTH-bit binary value over a valid/ready handshake and emits a deterministic bitstream of exactly 2^WIDTH bits, one bit per transfer.
- The stream contains exactly that value's number of ones.
- Feeding the stream into the team's bitstream counter for 2^WIDTH enabled cycles reproduces the value.

---
 rtl/bin2stoch_gen.sv | 105 ++++++++++
 tb/tb_bin2stoch_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2stoch_gen.sv
// rtl/bin2stoch_gen.sv - binary-to-stochastic bitstream generator (ramp or van der Corput sequence)
module bin2stoch_gen #(
    parameter int WIDTH = 4,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             bit_out,
    output logic             bit_last,
    output logic             busy
);

    localparam logic [WIDTH-1:0] LP_LAST = {WIDTH{1'b1}};

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_v;
    logic             r_valid;
    logic             r_bit;
    logic             r_last;
    logic             r_busy;

    logic             w_xfer;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_cnt_inc;

    // Comparison sequence element: identity (ramp) or bit-reversed index.
    function automatic logic [WIDTH-1:0] seq_elem(input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] s;
        s = c;
        if (MODE == 1) begin
            for (int i = 0; i < WIDTH; i++) begin
                s[i] = c[WIDTH-1-i];
            end
        end
        return s;
    endfunction

    always_comb begin
        w_xfer     = r_valid & out_ready;
        w_in_ready = ~abort & ((r_state == S_IDLE) | ((r_state == S_RUN) & out_ready & r_last));
        w_accept   = in_valid & w_in_ready;
        w_cnt_inc  = r_cnt + 1'b1;
    end

    // Next bit/last flags are computed from the next index so outputs stay registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_v     <= '0;
            r_valid <= 1'b0;
            r_bit   <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_bit   <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (w_accept) begin
            r_state <= S_RUN;
            r_v     <= in_data;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_bit   <= (in_data > seq_elem('0));
            r_last  <= 1'b0;
        end else if ((r_state == S_RUN) && w_xfer) begin
            if (r_last) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_valid <= 1'b0;
                r_bit   <= 1'b0;
                r_last  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_inc;
                r_bit  <= (r_v > seq_elem(w_cnt_inc));
                r_last <= (w_cnt_inc == LP_LAST);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign bit_out   = r_bit;
    assign bit_last  = r_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bin2stoch_gen.sv
// tb/tb_bin2stoch_gen.sv - bench for bin2stoch_gen, ramp and bit-reversed instances side by side
module tb_bin2stoch_gen;

    typedef bit bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_data = 4'd0;

    logic in_ready0, out_valid0, bit_out0, bit_last0, busy0;
    logic in_ready1, out_valid1, bit_out1, bit_last1, busy1;

    bin2stoch_gen #(.WIDTH(4), .MODE(0)) u_ramp (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .bit_out(bit_out0), .bit_last(bit_last0), .busy(busy0)
    );

    bin2stoch_gen #(.WIDTH(4), .MODE(1)) u_vdc (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .bit_out(bit_out1), .bit_last(bit_last1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bq_t q0, q1;
    int  last_pos[$];
    int  rdy_pos[$];
    int  nacc, acc_cyc, fv_cyc, gaps, stall_bad, ctl_diff, cyc;

    function automatic int rev4(input int k);
        int r = 0;
        for (int i = 0; i < 4; i++) if (((k >> i) & 1) == 1) r += 1 << (3 - i);
        return r;
    endfunction

    function automatic int ref_word(input int mode, input int v);
        int w = 0;
        for (int k = 0; k < 16; k++) begin
            int s = (mode == 1) ? rev4(k) : k;
            if (v > s) w |= 1 << k;
        end
        return w;
    endfunction

    function automatic int qword(input bq_t q, input int off);
        int w = 0;
        for (int k = 0; k < 16; k++) if (off + k < q.size() && q[off+k]) w |= 1 << k;
        return w;
    endfunction

    function automatic int ones(input bq_t q);
        int n = 0;
        foreach (q[i]) n += q[i];
        return n;
    endfunction

    // Offer v (then v2 if >= 0, back to back), stop after stop_at transfers.
    task automatic collect(input int v, input int v2, input int stall_pct, input int stop_at);
        bit pstall = 0;
        bit pb0 = 0, pb1 = 0, pl = 0, pbz = 0;
        q0.delete(); q1.delete(); last_pos.delete(); rdy_pos.delete();
        nacc = 0; acc_cyc = -1; fv_cyc = -1; gaps = 0; stall_bad = 0; ctl_diff = 0; cyc = 0;
        in_data = 4'(v);
        in_valid = 1'b1;
        for (int c = 0; c < 600; c++) begin
            bit acc;
            out_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (pstall && (out_valid0 !== 1'b1 || bit_out0 !== pb0 || bit_out1 !== pb1 ||
                           bit_last0 !== pl || busy0 !== pbz)) stall_bad++;
            if (in_ready1 !== in_ready0 || out_valid1 !== out_valid0 ||
                bit_last1 !== bit_last0 || busy1 !== busy0) ctl_diff++;
            acc = in_valid && in_ready0;
            if (acc) begin
                nacc++;
                if (nacc == 1) acc_cyc = cyc;
            end
            if (out_valid0 && fv_cyc < 0) fv_cyc = cyc;
            if (fv_cyc >= 0 && !out_valid0) gaps++;
            if (busy0 && in_ready0) rdy_pos.push_back(q0.size() + 1);
            if (out_valid0 && out_ready) begin
                q0.push_back(bit_out0);
                q1.push_back(bit_out1);
                if (bit_last0) last_pos.push_back(q0.size());
            end
            pstall = out_valid0 && !out_ready;
            pb0 = bit_out0; pb1 = bit_out1; pl = bit_last0; pbz = busy0;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (nacc == 1 && v2 >= 0) in_data = 4'(v2);
                else begin
                    in_valid = 1'b0;
                    in_data = 4'($urandom);
                end
            end
            if (q0.size() >= stop_at) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0d want 0", out_valid0); end
        total++; if (bit_out0 !== 1'b0 || bit_out1 !== 1'b0) begin bad++; $display("FAIL reset_bit_out: got %0d/%0d want 0/0", bit_out0, bit_out1); end
        total++; if (bit_last0 !== 1'b0) begin bad++; $display("FAIL reset_bit_last: got %0d want 0", bit_last0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0d want 0", busy0); end
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0d want 1", in_ready0); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        collect(5, -1, 0, 16);
        total++; if (q0.size() != 16) begin bad++; $display("FAIL ramp_len: got %0d want 16", q0.size()); end
        total++; if (qword(q0, 0) != 'h001F) begin bad++; $display("FAIL ramp_v5_bits: got %04h want 001f", qword(q0, 0)); end
        total++; if (qword(q1, 0) != ref_word(1, 5)) begin bad++; $display("FAIL vdc_v5_bits: got %04h want %04h", qword(q1, 0), ref_word(1, 5)); end
        total++; if (fv_cyc - acc_cyc != 1) begin bad++; $display("FAIL ramp_latency: got %0d want 1", fv_cyc - acc_cyc); end
        total++; if (last_pos.size() != 1 || last_pos[0] != 16) begin bad++; $display("FAIL ramp_last: got %0d marks want 1 at 16", last_pos.size()); end
        @(negedge clk);
        total++; if (out_valid0 !== 1'b0 || busy0 !== 1'b0) begin bad++; $display("FAIL ramp_idle_after: got valid=%0d busy=%0d want 0/0", out_valid0, busy0); end
        @(posedge clk); #1;
    endtask

    task automatic test_mode1();
        collect(8, -1, 0, 16);
        total++; if (qword(q1, 0) != 'h5555) begin bad++; $display("FAIL vdc_v8_bits: got %04h want 5555", qword(q1, 0)); end
        total++; if (qword(q0, 0) != 'h00FF) begin bad++; $display("FAIL ramp_v8_bits: got %04h want 00ff", qword(q0, 0)); end
        collect(3, -1, 0, 16);
        total++; if (qword(q1, 0) != 'h0111) begin bad++; $display("FAIL vdc_v3_bits: got %04h want 0111", qword(q1, 0)); end
        total++; if (qword(q0, 0) != 'h0007) begin bad++; $display("FAIL ramp_v3_bits: got %04h want 0007", qword(q0, 0)); end
    endtask

    task automatic test_boundaries();
        collect(0, -1, 0, 16);
        total++; if (q0.size() != 16 || qword(q0, 0) != 0 || qword(q1, 0) != 0) begin bad++; $display("FAIL v0_zeros: got len=%0d %04h/%04h want 16 0000/0000", q0.size(), qword(q0, 0), qword(q1, 0)); end
        collect(15, -1, 0, 16);
        total++; if (qword(q0, 0) != 'h7FFF) begin bad++; $display("FAIL ramp_v15_bits: got %04h want 7fff", qword(q0, 0)); end
        total++; if (qword(q1, 0) != 'h7FFF) begin bad++; $display("FAIL vdc_v15_bits: got %04h want 7fff", qword(q1, 0)); end
        total++; if (last_pos.size() != 1 || last_pos[0] != 16) begin bad++; $display("FAIL v15_last: got %0d marks want 1 at 16", last_pos.size()); end
    endtask

    task automatic test_back_to_back();
        collect(5, 10, 0, 32);
        total++; if (q0.size() != 32 || gaps != 0) begin bad++; $display("FAIL b2b_len_gaps: got len=%0d gaps=%0d want 32/0", q0.size(), gaps); end
        total++; if (last_pos.size() != 2 || last_pos[0] != 16 || last_pos[1] != 32) begin bad++; $display("FAIL b2b_last_pos: got %0d marks want 2 at 16,32", last_pos.size()); end
        total++; if (rdy_pos.size() != 2 || rdy_pos[0] != 16 || rdy_pos[1] != 32) begin bad++; $display("FAIL b2b_in_ready: got %0d busy-ready cycles want 2 at 16,32", rdy_pos.size()); end
        total++; if (nacc != 2) begin bad++; $display("FAIL b2b_accepts: got %0d want 2", nacc); end
        total++; if (qword(q0, 0) != ref_word(0, 5) || qword(q0, 16) != ref_word(0, 10)) begin bad++; $display("FAIL b2b_ramp_bits: got %04h,%04h want %04h,%04h", qword(q0, 0), qword(q0, 16), ref_word(0, 5), ref_word(0, 10)); end
        total++; if (qword(q1, 0) != ref_word(1, 5) || qword(q1, 16) != ref_word(1, 10)) begin bad++; $display("FAIL b2b_vdc_bits: got %04h,%04h want %04h,%04h", qword(q1, 0), qword(q1, 16), ref_word(1, 5), ref_word(1, 10)); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        collect(7, -1, 30, 16);
        total++; if (q0.size() != 16) begin bad++; $display("FAIL bp_len: got %0d want 16", q0.size()); end
        total++; if (ones(q0) != 7 || ones(q1) != 7) begin bad++; $display("FAIL bp_count: got %0d/%0d want 7/7", ones(q0), ones(q1)); end
        total++; if (last_pos.size() != 1) begin bad++; $display("FAIL bp_last: got %0d want 1", last_pos.size()); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_bad); end
        total++; if (qword(q0, 0) != ref_word(0, 7) || qword(q1, 0) != ref_word(1, 7)) begin bad++; $display("FAIL bp_bits: got %04h/%04h want %04h/%04h", qword(q0, 0), qword(q1, 0), ref_word(0, 7), ref_word(1, 7)); end
        total++; if (ctl_diff != 0) begin bad++; $display("FAIL bp_ctl_match: got %0d diffs want 0", ctl_diff); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int v = $urandom_range(15);
            collect(v, -1, $urandom_range(50), 16);
            total++; if (qword(q0, 0) != ref_word(0, v) || qword(q1, 0) != ref_word(1, v)) begin bad++; $display("FAIL rand_bits v=%0d: got %04h/%04h want %04h/%04h", v, qword(q0, 0), qword(q1, 0), ref_word(0, v), ref_word(1, v)); end
            total++; if (last_pos.size() != 1 || stall_bad != 0 || ctl_diff != 0) begin bad++; $display("FAIL rand_ctl v=%0d: got last=%0d stall=%0d diff=%0d want 1/0/0", v, last_pos.size(), stall_bad, ctl_diff); end
        end
    endtask

    task automatic test_abort();
        collect(11, -1, 0, 6);
        total++; if (qword(q0, 0) != (ref_word(0, 11) & 'h3F) || qword(q1, 0) != (ref_word(1, 11) & 'h3F)) begin bad++; $display("FAIL abort_prefix: got %04h/%04h want %04h/%04h", qword(q0, 0), qword(q1, 0), ref_word(0, 11) & 'h3F, ref_word(1, 11) & 'h3F); end
        abort = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 4'd9;
        @(negedge clk);
        total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL abort_in_ready: got %0d want 0", in_ready0); end
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || bit_last0 !== 1'b0) begin bad++; $display("FAIL abort_idle: got valid=%0d busy=%0d last=%0d want 0/0/0", out_valid0, busy0, bit_last0); end
        total++; if (last_pos.size() != 0) begin bad++; $display("FAIL abort_no_last: got %0d want 0", last_pos.size()); end
        @(posedge clk); #1;
        abort = 1'b1; in_valid = 1'b1; in_data = 4'd4;
        @(negedge clk);
        total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL abort_idle_block: got %0d want 0", in_ready0); end
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL abort_idle_no_accept: got %0d want 0", out_valid0); end
        @(posedge clk); #1;
        collect(9, -1, 0, 16);
        total++; if (qword(q0, 0) != ref_word(0, 9) || qword(q1, 0) != ref_word(1, 9) || fv_cyc - acc_cyc != 1) begin bad++; $display("FAIL abort_recover: got %04h/%04h lat=%0d want %04h/%04h lat=1", qword(q0, 0), qword(q1, 0), fv_cyc - acc_cyc, ref_word(0, 9), ref_word(1, 9)); end
    endtask

    task automatic test_reset_mid();
        collect(12, -1, 0, 9);
        total++; if (out_valid0 !== 1'b1 || bit_out0 !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got valid=%0d bit=%0d want 1/1", out_valid0, bit_out0); end
        #1 rst = 1'b0;
        #1;
        total++; if (out_valid0 !== 1'b0 || bit_out0 !== 1'b0 || bit_out1 !== 1'b0 || bit_last0 !== 1'b0 || busy0 !== 1'b0) begin bad++; $display("FAIL rstmid_async: got valid=%0d bit=%0d/%0d last=%0d busy=%0d want all 0", out_valid0, bit_out0, bit_out1, bit_last0, busy0); end
        total++; if (last_pos.size() != 0) begin bad++; $display("FAIL rstmid_no_last: got %0d want 0", last_pos.size()); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        collect(6, -1, 0, 16);
        total++; if (qword(q0, 0) != ref_word(0, 6) || qword(q1, 0) != ref_word(1, 6) || last_pos.size() != 1) begin bad++; $display("FAIL rstmid_recover: got %04h/%04h last=%0d want %04h/%04h last=1", qword(q0, 0), qword(q1, 0), last_pos.size(), ref_word(0, 6), ref_word(1, 6)); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_mode1();
        test_boundaries();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
